// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side master for an 8-bit combinational ALU.
// Takes register-level commands over valid/ready, reads operands from a small
// register file, drives the ALU, writes the result back and returns a response.
// Optional build macro ALU_SEQ_CMD_QUEUE_EN adds a 2-entry command FIFO in front
// of the FSM so commands can be accepted while a previous one is still running.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 4,
    parameter int RAW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RAW-1:0]   cmd_dst,
    input  logic [RAW-1:0]   cmd_sa,
    input  logic [RAW-1:0]   cmd_sb,
    input  logic             cmd_use_imm,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             cmd_use_c,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_cflag,
    input  logic             alu_zflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_flags,
    input  logic [RAW-1:0]   rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef struct packed {
        logic [2:0]       op;
        logic [RAW-1:0]   dst;
        logic [RAW-1:0]   sa;
        logic [RAW-1:0]   sb;
        logic             use_imm;
        logic [WIDTH-1:0] imm;
        logic             use_c;
    } cmd_t;

    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic             c_q, g_q, z_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [2:0]       alu_op_q;
    logic             alu_cin_q;
    logic [RAW-1:0]   dst_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;

    cmd_t cmd_in;
    cmd_t sel;
    logic start;

    assign cmd_in = '{op: cmd_op, dst: cmd_dst, sa: cmd_sa, sb: cmd_sb,
                      use_imm: cmd_use_imm, imm: cmd_imm, use_c: cmd_use_c};

`ifdef ALU_SEQ_CMD_QUEUE_EN
    cmd_t       fifo_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] fifo_cnt_q;
    logic       push, pop;

    // Ready is withheld only when full, so push and pop never coincide on a full FIFO.
    assign cmd_ready = (fifo_cnt_q != 2'd2);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (fifo_cnt_q != 2'd0);
    assign start     = pop;
    assign sel       = fifo_q[rd_ptr_q];

    // Command FIFO storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= cmd_in;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end
`else
    // Without a queue the FSM takes the command straight off the port in IDLE.
    assign cmd_ready = (state_q == S_IDLE);
    assign start     = cmd_valid && cmd_ready;
    assign sel       = cmd_in;
`endif

    // Next-state and ALU-latency counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    cnt_d   = 3'd0;
                end
            end
            S_EXEC: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB:    state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture operands at command start; they drive the ALU unchanged until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 3'd0;
            alu_cin_q <= 1'b0;
            dst_q     <= '0;
        end else if (start) begin
            alu_a_q   <= rf_q[sel.sa];
            alu_b_q   <= sel.use_imm ? sel.imm : rf_q[sel.sb];
            alu_op_q  <= sel.op;
            alu_cin_q <= sel.use_c & c_q;
            dst_q     <= sel.dst;
        end
    end

    // Write-back of result and flags, and the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            c_q         <= 1'b0;
            g_q         <= 1'b0;
            z_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (state_q == S_WB) begin
                rf_q[dst_q] <= alu_out;
                rsp_data_q  <= alu_out;
                rsp_valid_q <= 1'b1;
                z_q         <= alu_zflag;
                if (alu_op_q == OP_ADD || alu_op_q == OP_SUB) begin
                    c_q <= alu_cout;
                end
                if (alu_op_q == OP_CMP) begin
                    g_q <= alu_cflag;
                end
            end else if (state_q == S_RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = alu_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = {c_q, g_q, z_q};
    assign rd_data   = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_cmd_sequencer;

    localparam int WIDTH   = 8;
    localparam int RAW     = 2;
    localparam int ALU_LAT = 1;
`ifdef ALU_SEQ_CMD_QUEUE_EN
    localparam int QD = 1;
`else
    localparam int QD = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [RAW-1:0]   cmd_dst = '0, cmd_sa = '0, cmd_sb = '0;
    logic             cmd_use_imm = 1'b0;
    logic [WIDTH-1:0] cmd_imm = '0;
    logic             cmd_use_c = 1'b0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [2:0]       alu_op;
    logic             alu_cin, alu_cout, alu_cflag, alu_zflag;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_flags;
    logic [RAW-1:0]   rd_addr = '0;
    logic [WIDTH-1:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .NREGS(4), .RAW(RAW), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_use_c(cmd_use_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_cflag(alu_cflag), .alu_zflag(alu_zflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add, sub (carry = no borrow), and, or, xor, compare (passes a).
    logic [8:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_op)
            3'b000:  alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            3'b001:  alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, ~alu_cin};
            3'b010:  alu_t = {1'b0, alu_a & alu_b};
            3'b011:  alu_t = {1'b0, alu_a | alu_b};
            3'b100:  alu_t = {1'b0, alu_a ^ alu_b};
            default: alu_t = {1'b0, alu_a};
        endcase
        alu_out   = alu_t[7:0];
        alu_cout  = alu_t[8];
        alu_cflag = (alu_a > alu_b);
        alu_zflag = (alu_t[7:0] == 8'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command, wait for its response and check data, flags, latency and write-back.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input logic use_imm,
                          input logic [7:0] imm, input logic use_c, input logic [7:0] exp_old,
                          input logic [7:0] exp_data, input logic [2:0] exp_flags, input int hold);
        int n;
        int k;
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb;
        cmd_use_imm = use_imm; cmd_imm = imm; cmd_use_c = use_c;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        rd_addr = dst;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 30) begin
            if (n == ALU_LAT + 1 + QD) chk({tag, "_wb_old"}, 32'(rd_data), 32'(exp_old));
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, n, ALU_LAT + 2 + QD);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
        chk({tag, "_rf"}, 32'(rd_data), 32'(exp_data));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_hold_d"}, 32'(rsp_data), 32'(exp_data));
                chk({tag, "_hold_rdy"}, 32'(cmd_ready), 32'(QD));
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset state.
        #12;
        for (int i = 0; i < 4; i++) begin
            rd_addr = RAW'(i);
            #1 chk("rst_rf", 32'(rd_data), 32'd0);
        end
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rvalid", 32'(rsp_valid), 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_op, alu_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag    op      dst   sa    sb   imm? imm    use_c old    data   {C,G,Z}  hold
        do_cmd("add1", 3'b000, 2'd0, 2'd0, 2'd0, 1, 8'hF0, 0, 8'h00, 8'hF0, 3'b000, 0);
        do_cmd("add2", 3'b000, 2'd0, 2'd0, 2'd0, 1, 8'h20, 0, 8'hF0, 8'h10, 3'b100, 0);
        do_cmd("ld_r1", 3'b000, 2'd1, 2'd3, 2'd0, 1, 8'h05, 0, 8'h00, 8'h05, 3'b000, 0);
        do_cmd("sub1", 3'b001, 2'd1, 2'd1, 2'd0, 1, 8'h05, 0, 8'h05, 8'h00, 3'b101, 0);
        do_cmd("sub2", 3'b001, 2'd1, 2'd1, 2'd0, 1, 8'h06, 0, 8'h00, 8'hFA, 3'b000, 0);
        do_cmd("ld_r2", 3'b000, 2'd2, 2'd3, 2'd0, 1, 8'h09, 0, 8'h00, 8'h09, 3'b000, 0);
        do_cmd("cmp", 3'b101, 2'd3, 2'd2, 2'd0, 1, 8'h03, 0, 8'h00, 8'h09, 3'b010, 0);
        do_cmd("xor", 3'b100, 2'd2, 2'd2, 2'd2, 0, 8'h00, 0, 8'h09, 8'h00, 3'b011, 0);
        do_cmd("addc0", 3'b000, 2'd0, 2'd0, 2'd0, 1, 8'hF0, 0, 8'h10, 8'h00, 3'b111, 0);
        do_cmd("addc1", 3'b000, 2'd0, 2'd0, 2'd0, 1, 8'h01, 1, 8'h00, 8'h02, 3'b010, 0);
        do_cmd("bp", 3'b000, 2'd3, 2'd3, 2'd0, 1, 8'h01, 0, 8'h09, 8'h0A, 3'b010, 10);
        rd_addr = 2'd1;
        #1 chk("r1_final", 32'(rd_data), 32'hFA);

        // Reset while a command is executing: no response, register file cleared.
        @(negedge clk);
        cmd_op = 3'b000; cmd_dst = 2'd1; cmd_sa = 2'd1; cmd_use_imm = 1'b1;
        cmd_imm = 8'h01; cmd_use_c = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_rvalid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rf", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("post_rst_rvalid", 32'(rsp_valid), 32'd0);
        end
        chk("post_rst_rf", 32'(rd_data), 32'd0);
        chk("post_rst_flags", 32'(rsp_flags), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

`ifdef ALU_SEQ_CMD_QUEUE_EN
        // Occupy the FSM with a stalled response, then push three commands back to back.
        @(negedge clk);
        cmd_op = 3'b000; cmd_dst = 2'd0; cmd_sa = 2'd0; cmd_use_imm = 1'b1;
        cmd_imm = 8'h01; cmd_use_c = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("q_busy", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            chk("q_ready", 32'(cmd_ready), (i < 2) ? 32'd1 : 32'd0);
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 rd_addr = 2'd0;
        #1 chk("q_r0", 32'(rd_data), 32'd3);
        chk("q_ready_end", 32'(cmd_ready), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
